// File: rtl/k86_mem_pkg.sv
// Shared types and default sizes for the K8088 memory arbiter.
package k86_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_VID = 1'b1
    } owner_t;

    localparam int DEF_AW        = 20;
    localparam int DEF_DW        = 8;
    localparam int DEF_VID_BURST = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the memory arbiter.
// MEM_ARB_RR_EN defined   : strict round-robin against the last owner.
// MEM_ARB_RR_EN undefined : video priority, CPU wins once vid_run reaches VID_BURST.
module mem_arb_pick
    import k86_mem_pkg::*;
#(
    parameter int VID_BURST = DEF_VID_BURST
) (
    input  logic       cpu_req,
    input  logic       vid_req,
    input  logic [3:0] vid_run,
    input  owner_t     last_owner,
    output logic       grant,
    output owner_t     winner
);

`ifdef MEM_ARB_RR_EN
    logic unused_run;
    assign unused_run = ^vid_run;

    // Both active: hand the memory to whoever did not own it last.
    always_comb begin
        grant  = cpu_req | vid_req;
        winner = OWN_CPU;
        if (cpu_req && vid_req) begin
            winner = (last_owner == OWN_VID) ? OWN_CPU : OWN_VID;
        end else if (vid_req) begin
            winner = OWN_VID;
        end
    end
`else
    logic unused_owner;
    assign unused_owner = (last_owner == OWN_VID);

    // Video first, unless the waiting CPU has already sat out a full burst.
    always_comb begin
        grant  = cpu_req | vid_req;
        winner = OWN_CPU;
        if (vid_req && !(cpu_req && (vid_run == 4'(VID_BURST)))) begin
            winner = OWN_VID;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read byte memory between the K8088 core and video scanout.
// Each access runs IDLE -> ADDR -> DATA; the completion pulse appears in the following IDLE.
// Optional macro MEM_ARB_RR_EN selects round-robin arbitration (vid_run then held at 0).
module mem_arbiter
    import k86_mem_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int VID_BURST = DEF_VID_BURST
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_address,
    input  logic [DW-1:0] cpu_out,
    input  logic          cpu_we,
    output logic [DW-1:0] cpu_in,
    output logic          cpu_ce,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_address,
    output logic [DW-1:0] vid_data,
    output logic          vid_ack,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_out,
    output logic          mem_we,
    input  logic [DW-1:0] mem_in
);

    state_t     state;
    state_t     state_d;
    owner_t     owner;
    owner_t     winner;
    logic       grant;
    logic       acc_we;
    logic [3:0] vid_run;

    mem_arb_pick #(
        .VID_BURST (VID_BURST)
    ) u_pick (
        .cpu_req    (cpu_req),
        .vid_req    (vid_req),
        .vid_run    (vid_run),
        .last_owner (owner),
        .grant      (grant),
        .winner     (winner)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state: a grant in IDLE always runs the full three-cycle access.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (grant) state_d = ADDR;
            ADDR:    state_d = DATA;
            DATA:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory side registers, read-data latches and completion pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cpu_in      <= '0;
            cpu_ce      <= 1'b0;
            vid_data    <= '0;
            vid_ack     <= 1'b0;
            mem_address <= '0;
            mem_out     <= '0;
            mem_we      <= 1'b0;
            owner       <= OWN_CPU;
            acc_we      <= 1'b0;
        end else begin
            cpu_ce  <= 1'b0;
            vid_ack <= 1'b0;
            case (state)
                IDLE: begin
                    mem_we <= 1'b0;
                    if (grant) begin
                        owner <= winner;
                        if (winner == OWN_VID) begin
                            mem_address <= vid_address;
                            mem_out     <= '0;
                            acc_we      <= 1'b0;
                        end else begin
                            mem_address <= cpu_address;
                            mem_out     <= cpu_out;
                            mem_we      <= cpu_we;
                            acc_we      <= cpu_we;
                        end
                    end
                end
                ADDR: mem_we <= 1'b0;
                DATA: begin
                    if (owner == OWN_CPU) begin
                        cpu_ce <= 1'b1;
                        if (!acc_we) cpu_in <= mem_in;
                    end else begin
                        vid_data <= mem_in;
                        vid_ack  <= 1'b1;
                    end
                end
                default: mem_we <= 1'b0;
            endcase
        end
    end

`ifdef MEM_ARB_RR_EN
    assign vid_run = '0;
`else
    // Count video grants taken while the CPU is kept waiting.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vid_run <= '0;
        end else if (!cpu_req) begin
            vid_run <= '0;
        end else if (state == IDLE && grant) begin
            vid_run <= (winner == OWN_VID) ? vid_run + 4'd1 : 4'd0;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: memory array model, directed and random accesses.
module tb_mem_arbiter;

    localparam int AW        = 20;
    localparam int DW        = 8;
    localparam int VID_BURST = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          cpu_req = 1'b0;
    logic [AW-1:0] cpu_address = '0;
    logic [DW-1:0] cpu_out = '0;
    logic          cpu_we = 1'b0;
    logic [DW-1:0] cpu_in;
    logic          cpu_ce;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_address = '0;
    logic [DW-1:0] vid_data;
    logic          vid_ack;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_out;
    logic          mem_we;
    logic [DW-1:0] mem_in = '0;

    int tests_run = 0;
    int tests_failed = 0;
    bit last_vid = 1'b0;
    logic [7:0] last_cpu_rd = 8'h00;

    logic [7:0] env_mem [int];
    logic [7:0] ref_mem [int];

    mem_arbiter #(.AW(AW), .DW(DW), .VID_BURST(VID_BURST)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cpu_req     (cpu_req),
        .cpu_address (cpu_address),
        .cpu_out     (cpu_out),
        .cpu_we      (cpu_we),
        .cpu_in      (cpu_in),
        .cpu_ce      (cpu_ce),
        .vid_req     (vid_req),
        .vid_address (vid_address),
        .vid_data    (vid_data),
        .vid_ack     (vid_ack),
        .mem_address (mem_address),
        .mem_out     (mem_out),
        .mem_we      (mem_we),
        .mem_in      (mem_in)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] init_val(input logic [19:0] a);
        return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'h3C;
    endfunction

    function automatic logic [7:0] env_rd(input logic [19:0] a);
        if (env_mem.exists(int'(a))) return env_mem[int'(a)];
        return init_val(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [19:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_val(a);
    endfunction

    // Memory array: one-cycle synchronous read, write on the clock edge.
    always @(posedge clock) begin
        mem_in <= env_rd(mem_address);
        if (mem_we) env_mem[int'(mem_address)] = mem_out;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One isolated access; the requester drops its request in the pulse cycle.
    task automatic do_access(input bit is_vid, input bit we, input logic [19:0] a,
                             input logic [7:0] d, input string tag);
        int lat = 0;
        int we_cycles = 0;
        int stray = 0;
        bit done = 1'b0;
        logic [7:0] exp_data;
        @(negedge clock);
        if (is_vid) begin
            vid_req = 1'b1;
            vid_address = a;
        end else begin
            cpu_req = 1'b1;
            cpu_address = a;
            cpu_out = d;
            cpu_we = we;
        end
        exp_data = ref_rd(a);
        while (!done && lat < 10) begin
            @(negedge clock);
            lat++;
            if (mem_we) we_cycles++;
            if (is_vid ? cpu_ce : vid_ack) stray++;
            if (is_vid ? vid_ack : cpu_ce) done = 1'b1;
        end
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        vid_req = 1'b0;
        chk({tag, "_latency"}, lat, 3);
        chk({tag, "_stray"}, stray, 0);
        chk({tag, "_we_cycles"}, we_cycles, (!is_vid && we) ? 1 : 0);
        if (is_vid) begin
            chk({tag, "_vdata"}, vid_data, exp_data);
        end else if (we) begin
            chk({tag, "_cpu_in_kept"}, cpu_in, last_cpu_rd);
            ref_mem[int'(a)] = d;
        end else begin
            chk({tag, "_cdata"}, cpu_in, exp_data);
            last_cpu_rd = exp_data;
        end
        last_vid = is_vid;
    endtask

    // Both requests held: checks grant order, spacing and data per grant.
    task automatic contention;
        int t = 0;
        int last_t = 0;
        int n = 0;
        bit exp_vid;
`ifndef MEM_ARB_RR_EN
        int run = 0;
`endif
        logic [19:0] ca = 20'h12345;
        logic [19:0] va = 20'h23456;
        @(negedge clock);
        cpu_req = 1'b1;
        cpu_address = ca;
        cpu_we = 1'b0;
        vid_req = 1'b1;
        vid_address = va;
        while (n < 10 && t < 60) begin
            @(negedge clock);
            t++;
            if (cpu_ce && vid_ack) chk("cont_overlap", 1, 0);
            if (cpu_ce || vid_ack) begin
`ifdef MEM_ARB_RR_EN
                exp_vid = !last_vid;
`else
                if (run == VID_BURST) begin
                    exp_vid = 1'b0;
                    run = 0;
                end else begin
                    exp_vid = 1'b1;
                    run++;
                end
`endif
                chk("cont_src", vid_ack, exp_vid);
                chk("cont_gap", t - last_t, 3);
                last_t = t;
                if (vid_ack) chk("cont_vdata", vid_data, ref_rd(va));
                else chk("cont_cdata", cpu_in, ref_rd(ca));
                last_vid = vid_ack;
                n++;
            end
        end
        cpu_req = 1'b0;
        vid_req = 1'b0;
        chk("cont_count", n, 10);
        if (n > 0) last_cpu_rd = ref_rd(ca);
    endtask

    initial begin
        env_mem[int'(20'hBF0F1)] = 8'h56;
        env_mem[int'(20'hBF0F2)] = 8'hAF;
        ref_mem[int'(20'hBF0F1)] = 8'h56;
        ref_mem[int'(20'hBF0F2)] = 8'hAF;

        #2;
        chk("rst_outputs", {cpu_in, cpu_ce, vid_data, vid_ack, mem_we, mem_out}, '0);
        chk("rst_mem_address", mem_address, 20'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("idle_quiet", {mem_we, cpu_ce, vid_ack}, 3'b000);
        end

        do_access(1'b0, 1'b0, 20'hBF0F1, 8'h00, "cpu_rd_bf0f1");
        do_access(1'b0, 1'b0, 20'hBF0F2, 8'h00, "cpu_rd_bf0f2");
        do_access(1'b0, 1'b1, 20'h00400, 8'hA5, "cpu_wr_400");
        do_access(1'b0, 1'b0, 20'h00400, 8'h00, "cpu_rd_400");
        do_access(1'b1, 1'b0, 20'h00400, 8'h00, "vid_rd_400");

        for (int i = 0; i < 40; i++) begin
            int kind;
            logic [19:0] a;
            logic [7:0] d;
            kind = int'($urandom_range(0, 2));
            a = 20'h12340 + 20'($urandom_range(0, 15));
            d = 8'($urandom_range(0, 255));
            case (kind)
                0: do_access(1'b0, 1'b0, a, d, "rnd_cpu_rd");
                1: do_access(1'b0, 1'b1, a, d, "rnd_cpu_wr");
                default: do_access(1'b1, 1'b0, a, d, "rnd_vid_rd");
            endcase
        end

        contention();
        repeat (4) @(negedge clock);

        // Reset in the ADDR cycle of a write: write and acknowledge are both lost.
        @(negedge clock);
        cpu_req = 1'b1;
        cpu_address = 20'h00777;
        cpu_out = 8'h99;
        cpu_we = 1'b1;
        @(negedge clock);
        chk("rst_mid_we_before", mem_we, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_we_async", mem_we, 1'b0);
        chk("rst_mid_outputs", {cpu_in, cpu_ce, vid_data, vid_ack}, '0);
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("rst_mid_no_ack", {cpu_ce, vid_ack}, 2'b00);
        end
        reset_n = 1'b1;
        last_vid = 1'b0;
        last_cpu_rd = 8'h00;
        do_access(1'b0, 1'b0, 20'h00777, 8'h00, "post_rst_rd");
        do_access(1'b1, 1'b0, 20'hBF0F1, 8'h00, "post_rst_vid");

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
